// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse init sequencer and packet framer:
// protocol bytes, FSM encoding and the movement packet bundle.
package ps2_mouse_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] RSP_ID       = 8'h00;

    typedef enum logic [3:0] {
        S_SEND_RST = 4'd0,
        S_WAIT_TX1 = 4'd1,
        S_ACK1     = 4'd2,
        S_BAT      = 4'd3,
        S_ID       = 4'd4,
        S_SEND_EN  = 4'd5,
        S_WAIT_TX2 = 4'd6,
        S_ACK2     = 4'd7,
        S_STREAM   = 4'd8,
        S_RETRY    = 4'd9,
        S_ERROR    = 4'd10
    } state_t;

    typedef struct packed {
        logic [2:0] buttons;
        logic [8:0] dx;
        logic [8:0] dy;
        logic [1:0] ovf;
    } pkt_t;

    function automatic pkt_t pkt_from_bytes(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2
    );
        pkt_t p;
        p.buttons = b0[2:0];
        p.dx      = {b0[4], b1};
        p.dy      = {b0[5], b2};
        p.ovf     = b0[7:6];
        return p;
    endfunction

    // States in which a device response byte is expected and consumed.
    function automatic logic is_rsp_state(input state_t s);
        return (s == S_ACK1) || (s == S_BAT) ||
               (s == S_ID)   || (s == S_ACK2);
    endfunction

endpackage

// File: rtl/ps2_mouse_packet_asm.sv
// Frames the streaming byte sequence into 3-byte movement packets,
// with byte0 alignment check and inter-byte gap resync.
module ps2_mouse_packet_asm
    import ps2_mouse_pkg::*;
#(
    parameter int BYTE_GAP = 100_000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [1:0] byte_idx,
    output pkt_t       pkt,
    output logic       pkt_valid,
    output logic       sync_err
);

    localparam int GW = $clog2(BYTE_GAP + 1);

    logic [1:0]    idx_q;
    logic [7:0]    b0_q;
    logic [7:0]    b1_q;
    logic [GW-1:0] gap_q;
    logic          gap_hit;

    assign byte_idx = idx_q;
    assign gap_hit  = (idx_q != 2'd0) && (gap_q == GW'(BYTE_GAP));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            idx_q     <= 2'd0;
            b0_q      <= 8'h00;
            b1_q      <= 8'h00;
            gap_q     <= '0;
            pkt       <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (!enable) begin
                idx_q <= 2'd0;
                gap_q <= '0;
            end else if (rx_valid) begin
                gap_q <= '0;
                unique case (1'b1)
                    (idx_q == 2'd0): begin
                        if (rx_data[3]) begin
                            b0_q  <= rx_data;
                            idx_q <= 2'd1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                    (idx_q == 2'd1): begin
                        b1_q  <= rx_data;
                        idx_q <= 2'd2;
                    end
                    default: begin
                        pkt       <= pkt_from_bytes(b0_q, b1_q, rx_data);
                        pkt_valid <= 1'b1;
                        idx_q     <= 2'd0;
                    end
                endcase
            end else if (gap_hit) begin
                // Stalled mid-packet: drop the partial bytes and realign.
                idx_q    <= 2'd0;
                gap_q    <= '0;
                sync_err <= 1'b1;
            end else if (idx_q != 2'd0) begin
                gap_q <= gap_q + GW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse init sequencer (reset, enable reporting, retries) and
// wrapper around the streaming packet framer.
module ps2_mouse_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int RSP_TIMEOUT = 50_000_000,
    parameter int BYTE_GAP    = 100_000,
    parameter int MAX_RETRIES = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cmd_sent,
    input  logic       cmd_timeout,
    output logic [7:0] cmd_data,
    output logic       cmd_send,
    output logic       pkt_valid,
    output logic [2:0] pkt_buttons,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy,
    output logic [1:0] pkt_ovf,
    output logic       init_done,
    output logic       init_error,
    output logic       sync_err
);

    localparam int TW = $clog2(RSP_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tmr_q;
    logic [RW-1:0] retry_q;
    logic          tmo;
    logic          rx_acc;
    logic          last_try;
    logic          hotplug;
    logic          asm_en;
    logic          asm_rx;
    logic [1:0]    byte_idx;
    pkt_t          pkt;

    assign tmo      = (tmr_q == TW'(RSP_TIMEOUT - 1));
    assign rx_acc   = rx_valid && is_rsp_state(state_q);
    assign last_try = ((retry_q + RW'(1)) == RW'(MAX_RETRIES));

    // A BAT code at a packet boundary means the mouse was replugged.
    assign hotplug = (state_q == S_STREAM) && rx_valid &&
                     (rx_data == RSP_BAT_OK) && (byte_idx == 2'd0);
    assign asm_en  = (state_q == S_STREAM);
    assign asm_rx  = rx_valid && !hotplug;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_SEND_RST: state_d = S_WAIT_TX1;
            S_WAIT_TX1: begin
                if (cmd_sent)
                    state_d = S_ACK1;
                else if (cmd_timeout || tmo)
                    state_d = S_RETRY;
            end
            S_ACK1: begin
                if (rx_valid)
                    state_d = (rx_data == RSP_ACK) ? S_BAT : S_RETRY;
                else if (tmo)
                    state_d = S_RETRY;
            end
            S_BAT: begin
                if (rx_valid)
                    state_d = (rx_data == RSP_BAT_OK) ? S_ID : S_RETRY;
                else if (tmo)
                    state_d = S_RETRY;
            end
            S_ID: begin
                if (rx_valid)
                    state_d = (rx_data == RSP_ID) ? S_SEND_EN : S_RETRY;
                else if (tmo)
                    state_d = S_RETRY;
            end
            S_SEND_EN: state_d = S_WAIT_TX2;
            S_WAIT_TX2: begin
                if (cmd_sent)
                    state_d = S_ACK2;
                else if (cmd_timeout || tmo)
                    state_d = S_RETRY;
            end
            S_ACK2: begin
                if (rx_valid)
                    state_d = (rx_data == RSP_ACK) ? S_STREAM : S_RETRY;
                else if (tmo)
                    state_d = S_RETRY;
            end
            S_STREAM: begin
                if (hotplug)
                    state_d = S_ID;
            end
            S_RETRY: state_d = last_try ? S_ERROR : S_SEND_RST;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_SEND_RST;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_SEND_RST;
            tmr_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || rx_acc)
                tmr_q <= '0;
            else if (!tmo)
                tmr_q <= tmr_q + TW'(1);
            if (state_q == S_RETRY)
                retry_q <= retry_q + RW'(1);
        end
    end

    // Command outputs are registered so reset drives them low and
    // each single-cycle send state yields exactly one pulse.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cmd_data <= 8'h00;
            cmd_send <= 1'b0;
        end else begin
            cmd_send <= (state_q == S_SEND_RST) || (state_q == S_SEND_EN);
            if (state_q == S_SEND_RST)
                cmd_data <= CMD_RESET;
            else if (state_q == S_SEND_EN)
                cmd_data <= CMD_ENABLE;
        end
    end

    assign init_done  = (state_q == S_STREAM);
    assign init_error = (state_q == S_ERROR);

    ps2_mouse_packet_asm #(
        .BYTE_GAP (BYTE_GAP)
    ) u_asm (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .enable    (asm_en),
        .rx_data   (rx_data),
        .rx_valid  (asm_rx),
        .byte_idx  (byte_idx),
        .pkt       (pkt),
        .pkt_valid (pkt_valid),
        .sync_err  (sync_err)
    );

    assign pkt_buttons = pkt.buttons;
    assign pkt_dx      = pkt.dx;
    assign pkt_dy      = pkt.dy;
    assign pkt_ovf     = pkt.ovf;

endmodule
